sqrt_square_rem: RTL
====================

// Module: sqrt_square_rem
// PURPOSE
// - Inverse of the square-root pipeline: reconstructs radicand = root*root + remainder.
// - Uses an iterative shift-add multiplier, one multiplier bit per cycle.
// - Valid/ready handshake on both sides.
// - Used as a round-trip checker behind sqrt and as a standalone squarer in the same datapath.
// PARAMETERS
// - QW  4  root width (bits)
// - RW  5  remainder width (QW+1; legal remainder range 0..2*root)
// - DW  7  reconstructed radicand width (2*QW-1); wider results saturate
// PORTS
// - clk           in   1   rising-edge clock
// - rst_n         in   1   asynchronous active-low reset
// - in_valid      in   1   operands valid
// - in_ready      out  1   block can accept (high only in IDLE)
// - root_in       in   QW  unsigned root
// - rem_in        in   RW  unsigned remainder
// - out_valid     out  1   result valid; held until out_ready
// - out_ready     in   1   downstream accepts result
// - data_out      out  DW  root^2 + rem, saturated to all-ones on overflow
// - out_overflow  out  1   true sum exceeded 2^DW-1
// - out_rem_err   out  1   rem_in > 2*root_in (operand inconsistent with a sqrt result)
// BEHAVIOUR
// - Reset: clk and rst_n only, as fixed above; reset is asynchronous active-low.
//   - Asserting rst_n low, at any time, forces IDLE.
//   - In IDLE: in_ready=1, out_valid=0, data_out=0, out_overflow=0, out_rem_err=0.
//   - All internal registers are cleared.
//   - Any in-flight operation is discarded with no output pulse.
// - FSM states: IDLE, MUL, ADD, DONE.
// - IDLE: in_valid & in_ready at an edge captures operands.
//   - Multiplicand = multiplier = root_in. Also captures rem_in.
//   - acc (2*QW+1 bits) <= 0, bit counter <= 0, next state MUL.
// - MUL: each edge processes one multiplier bit, LSB first.
//   - If the bit = 1, acc += multiplicand << cnt.
//   - Then cnt++.
//   - After QW edges, go to ADD; cnt wraps to 0.
// - ADD: one edge.
//   - acc += rem.
//   - rem_err <= (rem > 2*root). Compare in RW+1 bits, no truncation.
//   - overflow <= (acc_new > 2^DW-1).
//   - data_out <= overflow ? all-ones : acc_new[DW-1:0].
//   - Go to DONE.
// - DONE: out_valid=1; data_out and flags stay stable.
//   - out_valid & out_ready at an edge returns to IDLE.
//   - out_valid drops and in_ready rises on that same edge.
// - Latency: out_valid rises QW+1 edges after the accepting edge (5 at defaults).
// - Throughput: one result per QW+3 cycles minimum.
// - Back-pressure: if out_ready=0, the block holds DONE indefinitely.
//   - in_ready stays 0; inputs are ignored.
// - in_valid while in_ready=0: ignored; the producer must hold it.
// - Accumulator width 2*QW+1 covers the worst case (2^QW-1)^2 + 2^RW-1 with no wrap.
// - Outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
// - Shared package sqrt_pkg holds:
//   - QW/RW/DW defaults.
//   - State enum typedef (IDLE, MUL, ADD, DONE).
//   - root_t/rem_t/rad_t typedefs, also used by sqrt.
// - No sub-module: FSM and shift-add datapath stay in one always_ff plus a small comb block.
// TESTING
// - root=11, rem=6 -> data_out=127, overflow=0, rem_err=0; out_valid 5 edges after accept.
// - root=0, rem=0 -> data_out=0, both flags 0.
// - root=15, rem=0 -> true 225; data_out=127, overflow=1.
// - root=3, rem=7 -> data_out=16, rem_err=1, overflow=0.
// - Back-pressure: hold out_ready=0 for 10 cycles.
//   - data_out and flags stable, in_ready=0, a new in_valid is ignored.
//   - Then out_ready=1 -> IDLE next edge; back-to-back root=5, rem=2 -> 27.
// - Reset mid-MUL: drop rst_n 2 edges after accept.
//   - Outputs go to their reset values immediately; no out_valid pulse.
//   - The next op (root=7, rem=0) -> 49.
// - Round-trip: every 7-bit value through sqrt, then this block.
//   - Radicand is recovered exactly; rem_err=0 and overflow=0 for every value.

Source files
------------

// File: rtl/sqrt_pkg.sv
// ---------------------------------------------------------------------------
// sqrt_pkg
// Shared definitions for the square-root datapath and its inverse
// (sqrt_square_rem).
//   - Default widths: root (QW_DEF), remainder (RW_DEF), radicand (DW_DEF).
//   - sqsr_state_t : FSM states of the squarer (IDLE, MUL, ADD, DONE).
//   - root_t / rem_t / rad_t : operand and result types at the default widths.
// ---------------------------------------------------------------------------
package sqrt_pkg;

   // Default root width; the remainder of an integer square root never
   // exceeds 2*root, so it needs one extra bit.
   localparam int QW_DEF = 4;
   localparam int RW_DEF = QW_DEF + 1;
   localparam int DW_DEF = 2 * QW_DEF - 1;

   typedef logic [QW_DEF-1:0] root_t;
   typedef logic [RW_DEF-1:0] rem_t;
   typedef logic [DW_DEF-1:0] rad_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ADD  = 2'd2,
      DONE = 2'd3
   } sqsr_state_t;

endpackage : sqrt_pkg

// File: rtl/sqrt_square_rem.sv
// ---------------------------------------------------------------------------
// sqrt_square_rem
// Reconstructs radicand = root*root + remainder using an iterative shift-add
// multiplier (one multiplier bit per clock, LSB first). It serves both as a
// round-trip checker behind the sqrt block and as a plain squarer.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   operands valid
//   in_ready     out  block can accept (high only in IDLE)
//   root_in      in   [QW-1:0] unsigned root
//   rem_in       in   [RW-1:0] unsigned remainder
//   out_valid    out  result valid, held until out_ready
//   out_ready    in   downstream accepts result
//   data_out     out  [DW-1:0] root^2 + rem, all-ones on overflow
//   out_overflow out  true sum exceeded 2^DW-1
//   out_rem_err  out  rem_in > 2*root_in
// ---------------------------------------------------------------------------
module sqrt_square_rem
   import sqrt_pkg::*;
#(
   parameter int QW = QW_DEF,
   parameter int RW = RW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [QW-1:0] root_in,
   input  logic [RW-1:0] rem_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] data_out,
   output logic          out_overflow,
   output logic          out_rem_err
);

   // Accumulator holds (2^QW-1)^2 + 2^RW-1 without wrapping.
   localparam int AW = 2 * QW + 1;
   localparam int CW = (QW > 1) ? $clog2(QW) : 1;
   localparam logic [AW-1:0] DMAX = {{(AW-DW){1'b0}}, {DW{1'b1}}};

   sqsr_state_t   r_state;
   sqsr_state_t   w_nextState;

   // Multiplicand and multiplier are the same value (the root), so a single
   // register serves as both.
   logic [QW-1:0] r_mcand;
   logic [RW-1:0] r_rem;
   logic [AW-1:0] r_acc;
   logic [CW-1:0] r_cnt;
   logic [DW-1:0] r_data;
   logic          r_ovf;
   logic          r_remErr;

   logic          w_lastBit;
   logic [AW-1:0] w_addend;
   logic [AW-1:0] w_accMul;
   logic [AW-1:0] w_accAdd;
   logic          w_ovf;
   logic          w_remErr;
   logic [DW-1:0] w_sat;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: MUL runs exactly QW cycles, ADD one cycle, DONE waits
   // for the downstream handshake.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_nextState = MUL;
         MUL:     if (w_lastBit) w_nextState = ADD;
         ADD:                    w_nextState = DONE;
         DONE:    if (out_ready) w_nextState = IDLE;
         default:                w_nextState = IDLE;
      endcase
   end

   // Datapath arithmetic. The remainder check is done one bit wider than the
   // remainder so that 2*root can never be truncated.
   always_comb begin
      w_lastBit = (r_cnt == CW'(QW - 1));
      w_addend  = r_mcand[r_cnt] ? (AW'(r_mcand) << r_cnt) : '0;
      w_accMul  = r_acc + w_addend;
      w_accAdd  = r_acc + AW'(r_rem);
      w_ovf     = (w_accAdd > DMAX);
      w_remErr  = ({1'b0, r_rem} > ((RW+1)'(r_mcand) << 1));
      w_sat     = w_ovf ? {DW{1'b1}} : w_accAdd[DW-1:0];
   end

   // Datapath registers. Result registers are cleared on the output
   // handshake so the outputs read zero whenever the block is idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand  <= '0;
         r_rem    <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_data   <= '0;
         r_ovf    <= 1'b0;
         r_remErr <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_mcand <= root_in;
                  r_rem   <= rem_in;
                  r_acc   <= '0;
                  r_cnt   <= '0;
               end
            end
            MUL: begin
               r_acc <= w_accMul;
               r_cnt <= w_lastBit ? '0 : r_cnt + CW'(1);
            end
            ADD: begin
               r_acc    <= w_accAdd;
               r_data   <= w_sat;
               r_ovf    <= w_ovf;
               r_remErr <= w_remErr;
            end
            DONE: begin
               if (out_ready) begin
                  r_data   <= '0;
                  r_ovf    <= 1'b0;
                  r_remErr <= 1'b0;
               end
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

   // Outputs come straight from registers; no input reaches them
   // combinationally.
   always_comb begin
      in_ready     = (r_state == IDLE);
      out_valid    = (r_state == DONE);
      data_out     = r_data;
      out_overflow = r_ovf;
      out_rem_err  = r_remErr;
   end

endmodule : sqrt_square_rem
